// File: rtl/dma_ring_sched.sv
// DMA ring scheduler: issues per-slot transfer commands into a DDR ring buffer,
// tracks ring fill against host releases, and exposes a small register map.
module dma_ring_sched #(
  parameter int unsigned SLOT_W = 4
) (
  input  logic        Bus2IP_Clk,
  input  logic        Bus2IP_Resetn,
  input  logic        up_sel,
  input  logic        up_rwn,
  input  logic [4:0]  up_addr,
  input  logic [31:0] up_wdata,
  output logic [31:0] up_rdata,
  output logic        up_ack,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] cmd_addr,
  output logic [17:0] cmd_len,
  input  logic        dma_irq,
  output logic        irq
);

  localparam int unsigned FW = SLOT_W + 1;
  localparam logic [FW-1:0] MAX_SLOTS = {1'b1, {SLOT_W{1'b0}}};
  localparam logic [FW-1:0] ONE_F     = {{SLOT_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_FULL  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                sel_q, sel_d, req_q, req_d, ack_q, ack_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                sync1_q, sync2_q, sync3_q;
  logic                enable_q, enable_d;
  logic [31:0]         base_q, base_d;
  logic [15:0]         len_q, len_d;
  logic [FW-1:0]       nslots_q, nslots_d;
  logic                irq_pend_q, irq_pend_d;
  logic [31:0]         done_cnt_q, done_cnt_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic [SLOT_W-1:0]   wr_slot_q, wr_slot_d;
  logic                err_q, err_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [31:0]         cmd_addr_q, cmd_addr_d;
  logic [17:0]         cmd_len_q, cmd_len_d;

  logic                wr_en, wr_ctrl, wr_base, wr_len, wr_nslots, wr_rel, wr_irq;
  logic                clear, done, busy_done, cfg_ok, load;
  logic [FW-1:0]       rel_amt, slot_inc;
  logic [31:0]         slot_off, status, rd_mux;

  always_comb begin
    sel_d = up_sel;
    req_d = up_sel & ~sel_q;
    ack_d = req_q;
  end

  assign wr_en     = ack_q & ~up_rwn;
  assign wr_ctrl   = wr_en && (up_addr == 5'h00);
  assign wr_base   = wr_en && (up_addr == 5'h01);
  assign wr_len    = wr_en && (up_addr == 5'h02);
  assign wr_nslots = wr_en && (up_addr == 5'h03);
  assign wr_rel    = wr_en && (up_addr == 5'h04);
  assign wr_irq    = wr_en && (up_addr == 5'h07);
  assign clear     = wr_ctrl & up_wdata[1];

  assign done      = sync2_q & ~sync3_q;
  assign busy_done = done && (state_q == ST_BUSY);
  assign cfg_ok    = (len_q != 16'd0) && (nslots_q != '0) && (nslots_q <= MAX_SLOTS);
  assign slot_inc  = {1'b0, wr_slot_q} + ONE_F;

  // Release saturates at the current fill so the ring count never underflows.
  always_comb begin
    rel_amt = '0;
    if (wr_rel) begin
      if (up_wdata >= {{(32-FW){1'b0}}, fill_q}) rel_amt = fill_q;
      else                                       rel_amt = up_wdata[FW-1:0];
    end
  end

  always_comb begin
    status        = '0;
    status[7:0]   = 8'(fill_q);
    status[15:8]  = 8'(wr_slot_q);
    status[17:16] = state_q;
    status[24]    = err_q;
  end

  always_comb begin
    rd_mux = '0;
    case (up_addr)
      5'h00:   rd_mux = {31'd0, enable_q};
      5'h01:   rd_mux = base_q;
      5'h02:   rd_mux = {16'd0, len_q};
      5'h03:   rd_mux = 32'(nslots_q);
      5'h05:   rd_mux = status;
      5'h06:   rd_mux = done_cnt_q;
      5'h07:   rd_mux = {31'd0, irq_pend_q};
      default: rd_mux = '0;
    endcase
    rdata_d = req_q ? rd_mux : rdata_q;
  end

  always_comb begin
    enable_d    = enable_q;
    base_d      = base_q;
    len_d       = len_q;
    nslots_d    = nslots_q;
    irq_pend_d  = irq_pend_q;
    done_cnt_d  = done_cnt_q;
    wr_slot_d   = wr_slot_q;
    err_d       = err_q;
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    load        = 1'b0;

    if (wr_ctrl)   enable_d = up_wdata[0];
    if (wr_base)   base_d   = {up_wdata[31:3], 3'b000};
    if (wr_len)    len_d    = up_wdata[15:0];
    if (wr_nslots) nslots_d = up_wdata[FW-1:0];
    if (wr_irq && up_wdata[0]) irq_pend_d = 1'b0;

    if (busy_done) begin
      done_cnt_d = done_cnt_q + 32'd1;
      irq_pend_d = 1'b1;
      wr_slot_d  = (slot_inc >= nslots_q) ? '0 : slot_inc[SLOT_W-1:0];
    end else if (done) begin
      err_d = 1'b1;
    end

    fill_d = fill_q + (busy_done ? ONE_F : '0) - rel_amt;

    if (clear && (state_q == ST_IDLE)) begin
      fill_d    = '0;
      wr_slot_d = '0;
      err_d     = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (enable_q && cfg_ok && (fill_q < nslots_q)) begin
          state_d = ST_ISSUE;
          load    = 1'b1;
        end else if (enable_q && (fill_q >= nslots_q)) begin
          state_d = ST_FULL;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          state_d     = ST_BUSY;
          cmd_valid_d = 1'b0;
        end
      end
      ST_BUSY: begin
        if (busy_done) begin
          if (!enable_q)              state_d = ST_IDLE;
          else if (fill_d >= nslots_q) state_d = ST_FULL;
          else begin
            state_d = ST_ISSUE;
            load    = 1'b1;
          end
        end
      end
      ST_FULL: begin
        if (!enable_q) state_d = ST_IDLE;
        else if (fill_q < nslots_q) begin
          state_d = ST_ISSUE;
          load    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Reload uses the post-advance slot so BUSY->ISSUE targets the next buffer.
    slot_off = 32'(wr_slot_d) * 32'(len_q);
    if (load) begin
      cmd_valid_d = 1'b1;
      cmd_addr_d  = base_q + (slot_off << 2);
      cmd_len_d   = {len_q, 2'b00};
    end
  end

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      sel_q       <= 1'b0;
      req_q       <= 1'b0;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      enable_q    <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      nslots_q    <= '0;
      irq_pend_q  <= 1'b0;
      done_cnt_q  <= '0;
      fill_q      <= '0;
      wr_slot_q   <= '0;
      err_q       <= 1'b0;
      state_q     <= ST_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
    end else begin
      sel_q       <= sel_d;
      req_q       <= req_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      sync1_q     <= dma_irq;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      enable_q    <= enable_d;
      base_q      <= base_d;
      len_q       <= len_d;
      nslots_q    <= nslots_d;
      irq_pend_q  <= irq_pend_d;
      done_cnt_q  <= done_cnt_d;
      fill_q      <= fill_d;
      wr_slot_q   <= wr_slot_d;
      err_q       <= err_d;
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
    end
  end

  assign up_rdata  = ack_q ? rdata_q : '0;
  assign up_ack    = ack_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_len   = cmd_len_q;
  assign irq       = irq_pend_q;

endmodule

// File: tb/tb_dma_ring_sched.sv
// Directed bench for dma_ring_sched: register access timing, ring issue/fill,
// backpressure, simultaneous done/release, spurious done and mid-transfer reset.
module tb_dma_ring_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic        up_sel, up_rwn;
  logic [4:0]  up_addr;
  logic [31:0] up_wdata, up_rdata;
  logic        up_ack, cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [17:0] cmd_len;
  logic        dma_irq, irq;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  logic [31:0] rd;

  dma_ring_sched #(.SLOT_W(4)) dut (
    .Bus2IP_Clk(clk), .Bus2IP_Resetn(resetn),
    .up_sel(up_sel), .up_rwn(up_rwn), .up_addr(up_addr), .up_wdata(up_wdata),
    .up_rdata(up_rdata), .up_ack(up_ack),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .dma_irq(dma_irq), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One bus access; optionally raises dma_irq so its done pulse lands on the commit edge.
  task automatic bus_access(input logic [4:0] a, input logic rwn, input logic [31:0] wd,
                            input logic with_done, output logic [31:0] data);
    int unsigned n;
    logic got;
    @(posedge clk); #1;
    up_sel = 1'b1; up_rwn = rwn; up_addr = a; up_wdata = wd;
    if (with_done) dma_irq = 1'b1;
    got = 1'b0; n = 0; data = '0;
    while (!got && n < 8) begin
      @(posedge clk); #1;
      n++;
      if (up_ack) begin got = 1'b1; data = up_rdata; end
    end
    check("ack_latency", n, 32'd2);
    @(posedge clk); #1;
    check("ack_one_cycle", {31'd0, up_ack}, 32'd0);
    up_sel = 1'b0;
    dma_irq = 1'b0;
  endtask

  task automatic reg_wr(input logic [4:0] a, input logic [31:0] wd);
    logic [31:0] dummy;
    bus_access(a, 1'b0, wd, 1'b0, dummy);
  endtask

  task automatic reg_rd(input logic [4:0] a, output logic [31:0] data);
    bus_access(a, 1'b1, 32'd0, 1'b0, data);
  endtask

  task automatic handshake;
    int unsigned n;
    cmd_ready = 1'b1;
    n = 0;
    while (cmd_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("handshake_drop", {31'd0, cmd_valid}, 32'd0);
    cmd_ready = 1'b0;
  endtask

  task automatic pulse_done;
    @(posedge clk); #1;
    dma_irq = 1'b1;
    repeat (3) @(posedge clk);
    #1 dma_irq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; up_sel = 1'b0; up_rwn = 1'b1; up_addr = '0; up_wdata = '0;
    cmd_ready = 1'b0; dma_irq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_cmd_addr", cmd_addr, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_up_ack", {31'd0, up_ack}, 32'd0);
    resetn = 1'b1;
    reg_rd(5'h05, rd); check("rst_status", rd, 32'd0);

    // Unmapped address and register readback
    reg_wr(5'h1F, 32'hFFFF_FFFF);
    reg_rd(5'h1F, rd); check("unmapped_rd", rd, 32'd0);
    reg_wr(5'h01, 32'h1000_0005);
    reg_rd(5'h01, rd); check("base_rd", rd, 32'h1000_0000);
    reg_wr(5'h02, 32'h0000_0100);
    reg_rd(5'h02, rd); check("len_rd", rd, 32'h0000_0100);
    reg_wr(5'h03, 32'd4);
    reg_rd(5'h03, rd); check("nslots_rd", rd, 32'd4);

    // Basic issue
    reg_wr(5'h00, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("basic_valid", {31'd0, cmd_valid}, 32'd1);
    check("basic_addr", cmd_addr, 32'h1000_0000);
    check("basic_len", {14'd0, cmd_len}, 32'h0000_0400);
    reg_rd(5'h05, rd); check("basic_status", rd, 32'h0001_0000);
    handshake;
    reg_rd(5'h05, rd); check("busy_status", rd, 32'h0002_0000);
    pulse_done;
    check("basic_next_addr", cmd_addr, 32'h1000_0400);
    check("basic_irq", {31'd0, irq}, 32'd1);
    reg_rd(5'h05, rd); check("basic_fill", rd, 32'h0001_0101);
    reg_rd(5'h06, rd); check("basic_donecnt", rd, 32'd1);

    // Fill the ring without releases
    for (int i = 0; i < 3; i++) begin
      handshake;
      pulse_done;
      if (i == 0) check("ring_addr2", cmd_addr, 32'h1000_0800);
      if (i == 1) check("ring_addr3", cmd_addr, 32'h1000_0C00);
    end
    reg_rd(5'h05, rd); check("full_status", rd, 32'h0003_0004);
    check("full_valid", {31'd0, cmd_valid}, 32'd0);
    reg_rd(5'h06, rd); check("full_donecnt", rd, 32'd4);
    reg_wr(5'h07, 32'd1);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    reg_wr(5'h04, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("wrap_valid", {31'd0, cmd_valid}, 32'd1);
    check("wrap_addr", cmd_addr, 32'h1000_0000);
    reg_rd(5'h05, rd); check("wrap_status", rd, 32'h0001_0003);

    // Done and release together at fill=2
    reg_wr(5'h04, 32'd1);
    handshake;
    bus_access(5'h04, 1'b0, 32'd1, 1'b1, rd);
    reg_rd(5'h05, rd); check("simul_status", rd, 32'h0001_0102);
    check("simul_addr", cmd_addr, 32'h1000_0400);
    reg_rd(5'h06, rd); check("simul_donecnt", rd, 32'd5);

    // Oversized release at fill=3
    handshake;
    pulse_done;
    reg_rd(5'h05, rd); check("pre_rel9_status", rd, 32'h0001_0203);
    reg_wr(5'h04, 32'd9);
    reg_rd(5'h05, rd); check("rel9_status", rd, 32'h0001_0200);

    // Backpressure with enable dropped mid-wait
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid_a", {31'd0, cmd_valid}, 32'd1);
      check("bp_addr_a", cmd_addr, 32'h1000_0800);
    end
    reg_wr(5'h00, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid_b", {31'd0, cmd_valid}, 32'd1);
      check("bp_addr_b", cmd_addr, 32'h1000_0800);
      check("bp_len_b", {14'd0, cmd_len}, 32'h0000_0400);
    end
    handshake;
    pulse_done;
    check("bp_idle_valid", {31'd0, cmd_valid}, 32'd0);
    reg_rd(5'h05, rd); check("bp_idle_status", rd, 32'h0000_0301);

    // Spurious done in IDLE, then clear
    pulse_done;
    reg_rd(5'h05, rd); check("spur_err", rd, 32'h0100_0301);
    reg_rd(5'h06, rd); check("spur_donecnt", rd, 32'd7);
    reg_wr(5'h00, 32'd2);
    reg_rd(5'h05, rd); check("clear_status", rd, 32'd0);
    reg_rd(5'h00, rd); check("ctrl_rd", rd, 32'd0);

    // Reset while BUSY
    reg_wr(5'h00, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("rst2_issue_addr", cmd_addr, 32'h1000_0000);
    handshake;
    check("rst2_irq_before", {31'd0, irq}, 32'd1);
    reg_rd(5'h06, rd); check("rst2_donecnt_before", rd, 32'd7);
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    check("rst2_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst2_cmd_addr", cmd_addr, 32'd0);
    check("rst2_cmd_len", {14'd0, cmd_len}, 32'd0);
    check("rst2_irq", {31'd0, irq}, 32'd0);
    check("rst2_up_ack", {31'd0, up_ack}, 32'd0);
    check("rst2_up_rdata", up_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    reg_rd(5'h05, rd); check("rst2_status", rd, 32'd0);
    reg_rd(5'h06, rd); check("rst2_donecnt", rd, 32'd0);
    reg_rd(5'h01, rd); check("rst2_base", rd, 32'd0);
    check("rst2_valid_after", {31'd0, cmd_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dma_ring_sched.md
DMA_RING_SCHED -- requirements
Module: dma_ring_sched

Interface
REQ-001 SHALL have parameter SLOT_W, default 4, meaning slot-index width; the ring holds at most 2^SLOT_W slots.
REQ-002 SHALL have port Bus2IP_Clk, input, 1, the clock.
REQ-003 SHALL have port Bus2IP_Resetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port up_sel / up_rwn / up_addr, input, 1/1/5, register access select, read-not-write and word address.
REQ-005 SHALL have port up_wdata, input, 32, register write data.
REQ-006 SHALL have port up_rdata, output, 32, register read data.
REQ-007 SHALL have port up_ack, output, 1, single-cycle access acknowledge.
REQ-008 SHALL have port cmd_valid / cmd_ready, output/input, 1/1, transfer-command handshake to the AXI-lite descriptor sequencer.
REQ-009 SHALL have port cmd_addr, output, 32, destination DDR byte address of the command.
REQ-010 SHALL have port cmd_len, output, 18, transfer length in bytes.
REQ-011 SHALL have port dma_irq, input, 1, asynchronous DMA completion level.
REQ-012 SHALL have port irq, output, 1, level interrupt to the host.

Function
REQ-013 SHALL treat a register access as new on the rising edge of up_sel: registered edge detect; up_ack high exactly one cycle, 2 cycles after up_sel rises; a write commits on the up_ack cycle; up_rdata is valid while up_ack is high.
REQ-014 SHALL implement the register map as follows:
- 0x00 CTRL: bit0 enable (RW); bit1 clear (write-1, self-clearing).
- 0x01 BASE: RW; bits[2:0] read 0.
- 0x02 LEN: RW; bits[15:0] = words per slot.
- 0x03 NSLOTS: RW; bits[SLOT_W:0].
- 0x04 RELEASE: write N, the count of buffers consumed by the host.
- 0x05 STATUS: RO; [7:0] fill, [15:8] wr_slot, [17:16] state, [24] err.
- 0x06 DONE_CNT: RO; 32-bit wrapping count.
- 0x07 IRQ: bit0 pending; write 1 clears it.
- Other addresses read 0 and ignore writes.
REQ-015 SHALL synchronise dma_irq through two flops and derive done as a single-cycle rising-edge pulse.
REQ-016 SHALL implement FSM states IDLE=0, ISSUE=1, BUSY=2, FULL=3.
REQ-017 IDLE: go to ISSUE when enable=1, LEN!=0, 1<=NSLOTS<=2^SLOT_W and fill<NSLOTS; go to FULL if fill>=NSLOTS.
REQ-018 IDLE->ISSUE: on the transition, SHALL register cmd_addr = BASE + wr_slot*LEN*4 (mod 2^32) and cmd_len = LEN*4.
REQ-019 ISSUE: cmd_valid=1; cmd_addr and cmd_len SHALL stay stable until cmd_ready; on cmd_valid&cmd_ready go to BUSY the next cycle with cmd_valid=0. Clearing enable SHALL NOT drop cmd_valid.
REQ-020 BUSY, on done: fill+1; DONE_CNT+1; irq pending set; wr_slot advances and wraps to 0 after NSLOTS-1.
REQ-021 BUSY, next state after done: IDLE if enable=0; FULL if new fill=NSLOTS; otherwise ISSUE, with cmd_addr reloaded per REQ-018.
REQ-022 FULL: go to ISSUE, with reload, once fill<NSLOTS and enable=1; go to IDLE if enable=0.
REQ-023 Each release SHALL reduce fill by min(N, fill). Done and release in the same cycle SHALL give fill_next = fill + done - min(N, fill).
REQ-024 A done pulse outside BUSY SHALL be ignored for counting and SHALL set err (sticky).
REQ-025 clear SHALL act only in IDLE, zeroing fill, wr_slot and err; outside IDLE it SHALL be ignored.
REQ-026 irq SHALL equal the irq pending bit.
REQ-027 Register writes to BASE/LEN/NSLOTS SHALL NOT affect an already-issued command.

Reset
REQ-028 On Bus2IP_Resetn=0 all of the following SHALL be 0 immediately, asynchronously: all registers, state (IDLE), fill, wr_slot, DONE_CNT, err, cmd_valid, cmd_addr, cmd_len, irq, up_ack, up_rdata and the synchroniser flops.
REQ-029 Reset mid-transfer SHALL abandon the command with no completion accounting.

Verification
REQ-030 Basic issue: BASE=0x10000000, LEN=0x100, NSLOTS=4, enable -> cmd_addr=0x10000000, cmd_len=0x400; after done, next cmd_addr=0x10000400, fill=1, irq=1.
REQ-031 Full ring: 4 dones with no release -> state FULL, cmd_valid=0; RELEASE=1 -> ISSUE with cmd_addr=0x10000000 (wrap).
REQ-032 Backpressure: cmd_ready held low 10 cycles -> cmd_valid and cmd_addr stable throughout; enable cleared meanwhile -> handshake completes, then IDLE after done.
REQ-033 Simultaneous events: done and RELEASE=1 in the same cycle at fill=2 -> fill=2; RELEASE=9 at fill=3 -> fill=0.
REQ-034 Spurious done: dma_irq edge in IDLE -> err=1, DONE_CNT unchanged; clear -> err=0.
REQ-035 Reset mid-BUSY: reset asserted -> all outputs 0, STATUS=0, DONE_CNT=0.
